// File: rtl/glip_uart_pkg.sv
// Shared definitions for the GLIP UART transmit scheduler and ingress filter:
// marker and control bytes, credit width, FSM state encoding and helpers that
// build the message bytes.
package glip_uart_pkg;

    localparam logic [7:0] MARKER       = 8'hFE;
    localparam logic [7:0] RST_CMD_BASE = 8'h81;

    localparam int CREDIT_W = 14;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

    // Scheduler FSM encoding, kept as plain constants so the ingress side
    // can share the same numbering.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ESC     = 3'd1;
    localparam state_t ST_CRED_HI = 3'd2;
    localparam state_t ST_CRED_LO = 3'd3;
    localparam state_t ST_RST_CMD = 3'd4;

    // Source that owns the TX byte while the FSM sits in IDLE.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RST  = 2'd1,
        GNT_CRED = 2'd2,
        GNT_DATA = 2'd3
    } grant_e;

    // Upper credit byte: bit 0 set marks it as a credit message, bit 7 clear.
    function automatic logic [7:0] cred_hi_byte(input logic [CREDIT_W-1:0] snap);
        return {1'b0, snap[13:8], 1'b1};
    endfunction

    // Reset control byte: 0x81 for value 0, 0x83 for value 1.
    function automatic logic [7:0] rst_cmd_byte(input logic val);
        return RST_CMD_BASE | {6'd0, val, 1'b0};
    endfunction

endpackage

// File: rtl/glip_uart_credit_counter.sv
// Ingress credit accounting: counts forwarded user bytes, saturates at the
// counter maximum, flags when a credit message is due and captures the value
// that the credit message carries.
module glip_uart_credit_counter
    import glip_uart_pkg::*;
#(
    parameter logic [CREDIT_W-1:0] INIT_CREDIT      = 14'd1024,
    parameter logic [CREDIT_W-1:0] CREDIT_THRESHOLD = 14'd32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                transfer_i,
    input  logic                snap_i,
    output logic                pending_o,
    output logic [CREDIT_W-1:0] snap_o
);

    logic [CREDIT_W-1:0] cnt_q, cnt_d;
    logic [CREDIT_W-1:0] snap_q, snap_d;
    logic                first_q, first_d;

    // Snapshot restarts the count; a transfer in that same cycle belongs to
    // the next message, so the count restarts at 1 instead of 0.
    always_comb begin
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        first_d = first_q;
        if (snap_i) begin
            snap_d  = cnt_q;
            cnt_d   = {{(CREDIT_W-1){1'b0}}, transfer_i};
            first_d = 1'b0;
        end else if (transfer_i && (cnt_q != CREDIT_MAX)) begin
            cnt_d = cnt_q + {{(CREDIT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter, snapshot and first-message flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= INIT_CREDIT;
            snap_q  <= '0;
            first_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            first_q <= first_d;
        end
    end

    assign pending_o = first_q | (cnt_q >= CREDIT_THRESHOLD);
    assign snap_o    = snap_q;

endmodule

// File: rtl/glip_uart_tx_scheduler.sv
// UART TX scheduler: multiplexes reset control messages, credit messages and
// escaped user data onto one byte stream. Multi-byte messages and escape
// pairs are sent atomically; an offered byte is never withdrawn.
module glip_uart_tx_scheduler
    import glip_uart_pkg::*;
#(
    parameter logic [CREDIT_W-1:0] INIT_CREDIT      = 14'd1024,
    parameter logic [CREDIT_W-1:0] CREDIT_THRESHOLD = 14'd32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       transfer,
    input  logic       rst_req,
    input  logic       rst_val,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    state_t state_q, state_d;
    grant_e lock_q, lock_d;
    logic   rst_pend_q, rst_pend_d;
    logic   rst_val_q, rst_val_d;
    logic   rst_cur_q, rst_cur_d;

    grant_e              gnt;
    logic                cred_pend;
    logic                snap_take;
    logic [CREDIT_W-1:0] snap;
    logic                accept;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                rx_ready;

    glip_uart_credit_counter #(
        .INIT_CREDIT      (INIT_CREDIT),
        .CREDIT_THRESHOLD (CREDIT_THRESHOLD)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .transfer_i (transfer),
        .snap_i     (snap_take),
        .pending_o  (cred_pend),
        .snap_o     (snap)
    );

    // Arbitration in IDLE; an offered-but-unaccepted grant stays locked.
    always_comb begin
        if (lock_q != GNT_NONE) begin
            gnt = lock_q;
        end else if (rst_pend_q) begin
            gnt = GNT_RST;
        end else if (cred_pend) begin
            gnt = GNT_CRED;
        end else begin
            gnt = GNT_DATA;
        end
    end

    // Byte presented on the TX side for the current state and grant.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                case (gnt)
                    GNT_RST, GNT_CRED: begin
                        tx_valid = 1'b1;
                        tx_data  = MARKER;
                    end
                    default: begin
                        tx_valid = in_valid;
                        tx_data  = in_valid ? in_data : 8'h00;
                        rx_ready = out_ready;
                    end
                endcase
            end
            ST_ESC: begin
                tx_valid = 1'b1;
                tx_data  = MARKER;
            end
            ST_CRED_HI: begin
                tx_valid = 1'b1;
                tx_data  = cred_hi_byte(snap);
            end
            ST_CRED_LO: begin
                tx_valid = 1'b1;
                tx_data  = snap[7:0];
            end
            ST_RST_CMD: begin
                tx_valid = 1'b1;
                tx_data  = rst_cmd_byte(rst_cur_q);
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
        // Nothing is offered or consumed while reset is held.
        if (rst) begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
            rx_ready = 1'b0;
        end
    end

    assign accept = tx_valid & out_ready;

    // Sequencing of message bytes and reset-request bookkeeping.
    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        rst_pend_d = rst_pend_q;
        rst_val_d  = rst_val_q;
        rst_cur_d  = rst_cur_q;
        snap_take  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    lock_d = GNT_NONE;
                    case (gnt)
                        GNT_RST: begin
                            // The value byte is frozen here so a later
                            // request cannot alter a byte being offered.
                            state_d    = ST_RST_CMD;
                            rst_pend_d = 1'b0;
                            rst_cur_d  = rst_req ? rst_val : rst_val_q;
                        end
                        GNT_CRED: begin
                            state_d   = ST_CRED_HI;
                            snap_take = 1'b1;
                        end
                        default: begin
                            if (in_data == MARKER) begin
                                state_d = ST_ESC;
                            end
                        end
                    endcase
                end else begin
                    lock_d = tx_valid ? gnt : GNT_NONE;
                end
            end
            ST_CRED_HI: begin
                if (accept) begin
                    state_d = ST_CRED_LO;
                end
            end
            ST_ESC, ST_CRED_LO, ST_RST_CMD: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A request arriving any other time arms (or re-arms) a message.
        if (rst_req && !((state_q == ST_IDLE) && accept && (gnt == GNT_RST))) begin
            rst_pend_d = 1'b1;
            rst_val_d  = rst_val;
        end
    end

    // Scheduler state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lock_q     <= GNT_NONE;
            rst_pend_q <= 1'b0;
            rst_val_q  <= 1'b0;
            rst_cur_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            rst_pend_q <= rst_pend_d;
            rst_val_q  <= rst_val_d;
            rst_cur_q  <= rst_cur_d;
        end
    end

    assign out_valid = tx_valid;
    assign out_data  = tx_data;
    assign in_ready  = rx_ready;
    assign busy      = rst | (state_q != ST_IDLE) | rst_pend_q | cred_pend;

endmodule
